gtx_link_init_ctrl: RTL and testbench
=====================================

Name: gtx_link_init_ctrl

Overview:
- Sequences power-up reset and SATA host OOB signalling for one GTX channel.
- Replaces the static tie-off block in src/gtx_drive.
- Cycle-counted CPLL/TX/RX reset, user-ready and data-valid qualification, then COMRESET/COMWAKE exchange with timeout and bounded retry.
- Sits between the GTX wrapper and the SATA link layer; drives link_up to the link layer.

Parameters:
CPLL_RST_CYC, 16, cycles cpllreset held high
LOCK_TMO_CYC, 65536, max cycles waiting for cplllock or tx/rx fsm done
DV_DLY_CYC, 1024, cycles after rx_fsm_done before data_valid asserts
OOB_TMO_CYC, 32768, max cycles waiting for a device OOB response
RETRY_MAX, 4, OOB attempts before error; legal range 1..15

Ports:
clk  in  1  user clock; all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins bring-up from IDLE or ERROR
cplllock  in  1  CPLL lock from GTX
tx_fsm_done  in  1  TX reset FSM done
rx_fsm_done  in  1  RX reset FSM done
txcomfinish  in  1  GTX finished sending OOB burst
rxcominitdet  in  1  COMINIT detected
rxcomwakedet  in  1  COMWAKE detected
rxelecidle  in  1  RX electrical idle
cpllreset  out  1  CPLL reset
gttxreset  out  1  GT TX reset
gtrxreset  out  1  GT RX reset
txuserrdy  out  1  TX user clocks stable
rxuserrdy  out  1  RX user clocks stable
data_valid  out  1  to GT RX fsm data-valid input
txelecidle  out  1  TX electrical idle
txcominit  out  1  one-cycle COMRESET request
txcomwake  out  1  one-cycle COMWAKE request
link_up  out  1  OOB complete, link layer may run
err  out  1  sticky failure flag
state  out  4  current state encoding (debug)

Behaviour:
- Reset values: cpllreset=1, gttxreset=1, gtrxreset=1, txelecidle=1; all other outputs 0; state=IDLE(0); counters and retry count 0. rst wins over every other input in the same cycle.
- Outputs are registered: visible the cycle after the state change.
- States/encoding:
  - IDLE(0): hold resets high. On start -> CPLL_RST.
  - CPLL_RST(1): cpllreset=1 for exactly CPLL_RST_CYC cycles -> WAIT_LOCK.
  - WAIT_LOCK(2): cpllreset=0. On cplllock -> GT_RST. If counter reaches LOCK_TMO_CYC -> ERROR.
  - GT_RST(3): gttxreset and gtrxreset deasserted together. txuserrdy and rxuserrdy assert the same cycle -> WAIT_DONE.
  - WAIT_DONE(4): wait for tx_fsm_done and rx_fsm_done both 1, then count DV_DLY_CYC and assert data_valid. Next cycle -> SEND_INIT. Timeout LOCK_TMO_CYC -> ERROR. data_valid stays 1 until rst or ERROR.
  - SEND_INIT(5): txelecidle=1, pulse txcominit one cycle, increment retry -> WAIT_INIT.
  - WAIT_INIT(6): once txcomfinish is seen, wait for rxcominitdet -> SEND_WAKE. On OOB_TMO_CYC timeout: retry<RETRY_MAX -> SEND_INIT, else ERROR.
  - SEND_WAKE(7): pulse txcomwake one cycle -> WAIT_WAKE.
  - WAIT_WAKE(8): rxcomwakedet -> WAIT_IDLE. Timeout is handled as in WAIT_INIT.
  - WAIT_IDLE(9): wait for rxelecidle==0, then txelecidle=0 -> LINK_UP. Timeout OOB_TMO_CYC -> retry rule.
  - LINK_UP(10): link_up=1. If cplllock drops -> ERROR, link_up=0 the next cycle.
  - ERROR(11): err=1 (sticky until rst or start), link_up=0, data_valid=0, all resets reasserted. start -> CPLL_RST with err cleared and retry=0.
- Timeout counter clears on every state entry. Timeout fires when the count equals the parameter minus 1, giving exactly N cycles.
- Simultaneous events: a timeout and a detect in the same cycle count as the detect. rxcominitdet while in WAIT_WAKE restarts at SEND_WAKE and does not consume a retry.
- start outside IDLE/ERROR is ignored.
- Counter width is sized by $clog2 of the largest timing parameter.

Test Plan:
- rst 3 cycles then start, with cplllock rising 100 cycles later and fsm_done rising 50 cycles after that -> cpllreset high exactly 16 cycles; data_valid rises 1024 cycles after both done; txcominit pulses once.
- cplllock never asserts -> ERROR after exactly 65536 cycles in WAIT_LOCK; err=1; cpllreset=1.
- Full OOB: pulse txcomfinish, rxcominitdet, rxcomwakedet, then drop rxelecidle -> sequence through states 5..10; link_up=1; txelecidle=0.
- No rxcominitdet -> exactly 4 txcominit pulses spaced OOB_TMO_CYC apart, then err=1.
- Remove cplllock in LINK_UP -> link_up=0 and err=1 next cycle; a later start -> clean bring-up with err=0.
- rst asserted mid-WAIT_WAKE -> all outputs return to their reset values on the next edge, state=0.

Source files
------------

// File: rtl/gtx_link_init_if.sv
// Signal bundle between the GTX link init controller, the GTX wrapper and the link layer.
interface gtx_link_init_if;
    logic       start;
    logic       cplllock;
    logic       tx_fsm_done;
    logic       rx_fsm_done;
    logic       txcomfinish;
    logic       rxcominitdet;
    logic       rxcomwakedet;
    logic       rxelecidle;
    logic       cpllreset;
    logic       gttxreset;
    logic       gtrxreset;
    logic       txuserrdy;
    logic       rxuserrdy;
    logic       data_valid;
    logic       txelecidle;
    logic       txcominit;
    logic       txcomwake;
    logic       link_up;
    logic       err;
    logic [3:0] state;

    // Controller side.
    modport master (
        input  start, cplllock, tx_fsm_done, rx_fsm_done, txcomfinish,
               rxcominitdet, rxcomwakedet, rxelecidle,
        output cpllreset, gttxreset, gtrxreset, txuserrdy, rxuserrdy, data_valid,
               txelecidle, txcominit, txcomwake, link_up, err, state
    );

    // GTX wrapper / link layer side.
    modport slave (
        output start, cplllock, tx_fsm_done, rx_fsm_done, txcomfinish,
               rxcominitdet, rxcomwakedet, rxelecidle,
        input  cpllreset, gttxreset, gtrxreset, txuserrdy, rxuserrdy, data_valid,
               txelecidle, txcominit, txcomwake, link_up, err, state
    );
endinterface

// File: rtl/gtx_link_init_ctrl.sv
// GTX power-up reset sequencing and SATA host OOB (COMRESET/COMWAKE) exchange with retry.
module gtx_link_init_ctrl #(
    parameter int unsigned CPLL_RST_CYC = 16,
    parameter int unsigned LOCK_TMO_CYC = 65536,
    parameter int unsigned DV_DLY_CYC   = 1024,
    parameter int unsigned OOB_TMO_CYC  = 32768,
    parameter int unsigned RETRY_MAX    = 4
) (
    input  logic            clk,
    input  logic            rst,
    gtx_link_init_if.master bus_io
);

    localparam int unsigned MaxA   = (CPLL_RST_CYC > LOCK_TMO_CYC) ? CPLL_RST_CYC : LOCK_TMO_CYC;
    localparam int unsigned MaxB   = (DV_DLY_CYC > OOB_TMO_CYC) ? DV_DLY_CYC : OOB_TMO_CYC;
    localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t CpllLast = cnt_t'(CPLL_RST_CYC - 1);
    localparam cnt_t LockLast = cnt_t'(LOCK_TMO_CYC - 1);
    localparam cnt_t DvLast   = cnt_t'(DV_DLY_CYC - 1);
    localparam cnt_t OobLast  = cnt_t'(OOB_TMO_CYC - 1);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StCpllRst  = 4'd1,
        StWaitLock = 4'd2,
        StGtRst    = 4'd3,
        StWaitDone = 4'd4,
        StSendInit = 4'd5,
        StWaitInit = 4'd6,
        StSendWake = 4'd7,
        StWaitWake = 4'd8,
        StWaitIdle = 4'd9,
        StLinkUp   = 4'd10,
        StError    = 4'd11
    } state_e;

    state_e     state_q, state_d, oob_fail;
    cnt_t       cnt_q, cnt_d;
    logic [3:0] retry_q, retry_d;
    logic       fin_q, fin_d;    // txcomfinish seen in WAIT_INIT
    logic       done_q, done_d;  // both reset FSMs done; cnt_q now times the data-valid delay
    logic       dv_q, dv_d;

    logic cpllreset_q, cpllreset_d, gtrst_q, gtrst_d, userrdy_q, userrdy_d;
    logic txelecidle_q, txelecidle_d, txcominit_q, txcominit_d, txcomwake_q, txcomwake_d;
    logic link_up_q, link_up_d, err_q, err_d;

    // Next-state, timeout counter, retry count and qualification flags.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        retry_d  = retry_q;
        fin_d    = fin_q;
        done_d   = done_q;
        dv_d     = dv_q;
        oob_fail = (retry_q < 4'(RETRY_MAX)) ? StSendInit : StError;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus_io.start) begin
                    state_d = StCpllRst;
                    retry_d = '0;
                end
            end
            StCpllRst:  if (cnt_q == CpllLast) state_d = StWaitLock;
            StWaitLock: begin
                if (bus_io.cplllock)       state_d = StGtRst;
                else if (cnt_q == LockLast) state_d = StError;
            end
            StGtRst:    state_d = StWaitDone;
            StWaitDone: begin
                if (dv_q) begin
                    state_d = StSendInit;
                end else if (done_q) begin
                    if (cnt_q == DvLast) dv_d = 1'b1;
                end else if (bus_io.tx_fsm_done && bus_io.rx_fsm_done) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                end else if (cnt_q == LockLast) begin
                    state_d = StError;
                end
            end
            StSendInit: begin
                retry_d = retry_q + 4'd1;
                state_d = StWaitInit;
            end
            StWaitInit: begin
                if (bus_io.txcomfinish) fin_d = 1'b1;
                if (bus_io.rxcominitdet && (fin_q || bus_io.txcomfinish)) state_d = StSendWake;
                else if (cnt_q == OobLast)                                state_d = oob_fail;
            end
            StSendWake: state_d = StWaitWake;
            StWaitWake: begin
                // A fresh COMINIT restarts the wake phase without costing a retry.
                if (bus_io.rxcomwakedet)      state_d = StWaitIdle;
                else if (bus_io.rxcominitdet) state_d = StSendWake;
                else if (cnt_q == OobLast)    state_d = oob_fail;
            end
            StWaitIdle: begin
                if (!bus_io.rxelecidle)    state_d = StLinkUp;
                else if (cnt_q == OobLast) state_d = oob_fail;
            end
            StLinkUp: begin
                cnt_d = '0;
                if (!bus_io.cplllock) state_d = StError;
            end
            StError: begin
                cnt_d = '0;
                if (bus_io.start) begin
                    state_d = StCpllRst;
                    retry_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            fin_d  = 1'b0;
            done_d = 1'b0;
        end
        if (state_d == StError) dv_d = 1'b0;
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        cpllreset_d  = (state_d == StIdle) || (state_d == StCpllRst) || (state_d == StError);
        gtrst_d      = cpllreset_d || (state_d == StWaitLock);
        userrdy_d    = !gtrst_d;
        txelecidle_d = (state_d != StLinkUp);
        txcominit_d  = (state_d == StSendInit);
        txcomwake_d  = (state_d == StSendWake);
        link_up_d    = (state_d == StLinkUp);
        err_d        = (state_d == StError);
    end

    // State, counter and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            retry_q <= '0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
            dv_q    <= dv_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpllreset_q  <= 1'b1;
            gtrst_q      <= 1'b1;
            userrdy_q    <= 1'b0;
            txelecidle_q <= 1'b1;
            txcominit_q  <= 1'b0;
            txcomwake_q  <= 1'b0;
            link_up_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cpllreset_q  <= cpllreset_d;
            gtrst_q      <= gtrst_d;
            userrdy_q    <= userrdy_d;
            txelecidle_q <= txelecidle_d;
            txcominit_q  <= txcominit_d;
            txcomwake_q  <= txcomwake_d;
            link_up_q    <= link_up_d;
            err_q        <= err_d;
        end
    end

    assign bus_io.cpllreset  = cpllreset_q;
    assign bus_io.gttxreset  = gtrst_q;
    assign bus_io.gtrxreset  = gtrst_q;
    assign bus_io.txuserrdy  = userrdy_q;
    assign bus_io.rxuserrdy  = userrdy_q;
    assign bus_io.data_valid = dv_q;
    assign bus_io.txelecidle = txelecidle_q;
    assign bus_io.txcominit  = txcominit_q;
    assign bus_io.txcomwake  = txcomwake_q;
    assign bus_io.link_up    = link_up_q;
    assign bus_io.err        = err_q;
    assign bus_io.state      = state_q;

endmodule

// File: tb/tb_gtx_link_init_ctrl.sv
// Bench for gtx_link_init_ctrl: dwell-time reference model compared every cycle, directed
// bring-up / timeout / retry scenarios with literal expectations, then a random phase.
module tb_gtx_link_init_ctrl;

    localparam int P_CPLL  = 16;
    localparam int P_LOCK  = 300;
    localparam int P_DV    = 40;
    localparam int P_OOB   = 50;
    localparam int P_RETRY = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gtx_link_init_if bus ();

    gtx_link_init_ctrl #(
        .CPLL_RST_CYC (P_CPLL),
        .LOCK_TMO_CYC (P_LOCK),
        .DV_DLY_CYC   (P_DV),
        .OOB_TMO_CYC  (P_OOB),
        .RETRY_MAX    (P_RETRY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [14:0] dut_vec;
    assign dut_vec = {bus.state, bus.cpllreset, bus.gttxreset, bus.gtrxreset, bus.txuserrdy,
                      bus.rxuserrdy, bus.data_valid, bus.txelecidle, bus.txcominit,
                      bus.txcomwake, bus.link_up, bus.err};

    // Reference model: current state number, cycles spent in it, and OOB bookkeeping.
    int m_state = 0;
    int m_t     = 0;
    int m_retry = 0;
    bit m_dv    = 0;
    bit m_fin   = 0;
    int m_da    = -1;  // dwell time at which both reset FSMs were first seen done

    function automatic int oob_fail(input int r);
        return (r < P_RETRY) ? 5 : 11;
    endfunction

    // Expected output vector from the state table.
    function automatic logic [14:0] exp_vec(input int st, input bit dv);
        logic cr, gr, ur;
        cr = (st == 0) || (st == 1) || (st == 11);
        gr = (st <= 2) || (st == 11);
        ur = (st >= 3) && (st <= 10);
        return {4'(st), cr, gr, gr, ur, ur, dv, (st != 10), (st == 5), (st == 7), (st == 10),
                (st == 11)};
    endfunction

    always @(posedge clk) begin : model_upd
        int ns, nr, nt, nda;
        bit ndv, nfin, both, tmo;
        ns   = m_state;
        nr   = m_retry;
        nt   = m_t + 1;
        nda  = m_da;
        ndv  = m_dv;
        nfin = m_fin;
        both = bus.tx_fsm_done && bus.rx_fsm_done;
        tmo  = (m_t == P_OOB - 1);
        if (rst) begin
            ns = 0; nr = 0; nt = 0; nda = -1; ndv = 0; nfin = 0;
        end else begin
            case (m_state)
                0, 11: if (bus.start) begin ns = 1; nr = 0; end
                1: if (m_t == P_CPLL - 1) ns = 2;
                2: if (bus.cplllock) ns = 3; else if (m_t == P_LOCK - 1) ns = 11;
                3: ns = 4;
                4: begin
                    if (m_dv) ns = 5;
                    else if (m_da >= 0) begin
                        if (m_t - m_da == P_DV) ndv = 1;
                    end else if (both) nda = m_t;
                    else if (m_t == P_LOCK - 1) ns = 11;
                end
                5: begin nr = m_retry + 1; ns = 6; end
                6: begin
                    if (bus.txcomfinish) nfin = 1;
                    if (bus.rxcominitdet && (m_fin || bus.txcomfinish)) ns = 7;
                    else if (tmo) ns = oob_fail(m_retry);
                end
                7: ns = 8;
                8: begin
                    if (bus.rxcomwakedet) ns = 9;
                    else if (bus.rxcominitdet) ns = 7;
                    else if (tmo) ns = oob_fail(m_retry);
                end
                9: if (!bus.rxelecidle) ns = 10; else if (tmo) ns = oob_fail(m_retry);
                10: if (!bus.cplllock) ns = 11;
                default: ns = 0;
            endcase
            if (ns != m_state) begin nt = 0; nda = -1; nfin = 0; end
            if (ns == 11) ndv = 0;
        end
        m_state <= ns;
        m_retry <= nr;
        m_t     <= nt;
        m_da    <= nda;
        m_dv    <= ndv;
        m_fin   <= nfin;
    end

    // Monitor: per-cycle compare plus measurements used by the literal checks.
    int         cyc = 0;
    logic [3:0] prev_st = 4'd0;
    logic       prev_dv = 1'b0;
    int         cur_run = 0;
    int         run_len[16];
    int         init_pulses = 0;
    int         last_init = -1;
    int         init_gap = 0;
    bit         both_seen = 0;
    int         both_edge = 0;
    int         dv_delay = 0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        n_cmp++;
        if (dut_vec !== exp_vec(m_state, m_dv)) begin
            n_fail++;
            $display("FAIL cycle_cmp @%0d: dut=%h model=%h (model state %0d)", cyc, dut_vec,
                     exp_vec(m_state, m_dv), m_state);
        end
        if (prev_st == 4'd4 && bus.tx_fsm_done && bus.rx_fsm_done && !both_seen) begin
            both_seen = 1;
            both_edge = cyc;
        end
        if (!prev_dv && bus.data_valid === 1'b1 && both_seen) begin
            dv_delay  = cyc - both_edge;
            both_seen = 0;
        end
        if (bus.txcominit === 1'b1) begin
            init_pulses++;
            if (last_init >= 0) init_gap = cyc - last_init;
            last_init = cyc;
        end
        if (bus.state == prev_st) cur_run++;
        else begin
            run_len[prev_st] = cur_run;
            cur_run = 1;
        end
        if (bus.state != 4'd4) both_seen = 0;
        prev_st = bus.state;
        prev_dv = bus.data_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (bus.state == 4'(s)) hit = 1;
            else @(negedge clk);
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_%s: state=%0d never reached %0d", tag, bus.state, s);
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            0: bus.start = 1'b1;
            1: bus.txcomfinish = 1'b1;
            2: bus.rxcominitdet = 1'b1;
            default: bus.rxcomwakedet = 1'b1;
        endcase
        tick(1);
        bus.start = 1'b0;
        bus.txcomfinish = 1'b0;
        bus.rxcominitdet = 1'b0;
        bus.rxcomwakedet = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.cplllock = 1'b0; bus.tx_fsm_done = 1'b0; bus.rx_fsm_done = 1'b0;
        bus.txcomfinish = 1'b0; bus.rxcominitdet = 1'b0; bus.rxcomwakedet = 1'b0;
        bus.rxelecidle = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_vec", int'(dut_vec), 'h0710);

        // Bring-up with spaced lock/done, then a full OOB exchange.
        init_pulses = 0;
        pulse(0);
        tick(99);
        bus.cplllock = 1'b1;
        tick(50);
        bus.tx_fsm_done = 1'b1;
        bus.rx_fsm_done = 1'b1;
        wait_state(5, 200, "send_init");
        check("cpll_rst_len", run_len[1], P_CPLL);
        check("dv_delay", dv_delay, P_DV);
        wait_state(6, 10, "wait_init");
        tick($urandom_range(1, 10)); pulse(1);
        tick($urandom_range(1, 10)); pulse(2);
        wait_state(8, 10, "wait_wake");
        tick($urandom_range(1, 10)); pulse(2);  // COMINIT again: restart wake phase
        wait_state(7, 5, "resend_wake");
        wait_state(8, 5, "wait_wake2");
        tick($urandom_range(1, 10)); pulse(3);
        wait_state(9, 10, "wait_idle");
        tick($urandom_range(1, 10));
        bus.rxelecidle = 1'b0;
        wait_state(10, 10, "link_up");
        check("link_up", bus.link_up, 1);
        check("txelecidle_low", bus.txelecidle, 0);
        check("single_cominit", init_pulses, 1);
        pulse(0);
        tick(2);
        check("start_ignored", bus.state, 10);

        // Lose CPLL lock in LINK_UP.
        bus.cplllock = 1'b0;
        tick(1);
        check("drop_link_up", bus.link_up, 0);
        check("drop_err", bus.err, 1);
        check("drop_dv", bus.data_valid, 0);

        // Clean restart, then reset while waiting for COMWAKE.
        bus.cplllock = 1'b1;
        bus.rxelecidle = 1'b1;
        pulse(0);
        check("restart_err", bus.err, 0);
        wait_state(6, 200, "wait_init_b");
        bus.txcomfinish = 1'b1;
        pulse(2);
        wait_state(8, 10, "wait_wake_b");
        tick(3);
        rst = 1'b1;
        tick(1);
        check("rst_mid_wake", int'(dut_vec), 'h0710);
        rst = 1'b0;
        tick(2);

        // CPLL never locks.
        bus.cplllock = 1'b0;
        pulse(0);
        wait_state(11, P_LOCK + 40, "lock_tmo");
        check("lock_tmo_len", run_len[2], P_LOCK);
        check("lock_tmo_err", bus.err, 1);
        check("lock_tmo_cpllreset", bus.cplllock ? 0 : int'(bus.cpllreset), 1);

        // Device never answers COMRESET.
        bus.cplllock = 1'b1;
        init_pulses = 0;
        last_init = -1;
        pulse(0);
        tick(30);
        pulse(1);
        wait_state(11, 1000, "retry_exhaust");
        check("retry_pulses", init_pulses, P_RETRY);
        check("retry_gap", init_gap, P_OOB + 1);
        check("retry_err", bus.err, 1);

        // Random phase against the model.
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 1999) == 0);
            bus.start = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) bus.cplllock = ~bus.cplllock;
            else if (!bus.cplllock && $urandom_range(0, 29) == 0) bus.cplllock = 1'b1;
            bus.tx_fsm_done = ($urandom_range(0, 9) != 0);
            bus.rx_fsm_done = ($urandom_range(0, 9) != 0);
            bus.txcomfinish = ($urandom_range(0, 7) == 0);
            bus.rxcominitdet = ($urandom_range(0, 24) == 0);
            bus.rxcomwakedet = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 19) == 0) bus.rxelecidle = ~bus.rxelecidle;
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
